// File: rtl/alarm_controller_if.sv
// Alarm controller signal bundle: key levels, tick and time inputs on one
// side; alarm counter increment pulses and display/edit status on the other.
interface alarm_controller_if;
    logic        left_key;
    logic        right_key;
    logic        up_key;
    logic        down_key;
    logic        sec_tick;
    logic [23:0] cur_time;
    logic [23:0] alarm_time;
    logic        alarm_upsec;
    logic        alarm_upmin;
    logic        alarm_uphour;
    logic        edit_mode;
    logic [1:0]  field_sel;
    logic        armed;
    logic        ringing;
    logic        ring_blink;

    // Environment side: drives keys, tick and times; observes controller status
    modport master (
        output left_key, right_key, up_key, down_key, sec_tick, cur_time, alarm_time,
        input  alarm_upsec, alarm_upmin, alarm_uphour, edit_mode, field_sel,
               armed, ringing, ring_blink
    );

    // Controller side
    modport slave (
        input  left_key, right_key, up_key, down_key, sec_tick, cur_time, alarm_time,
        output alarm_upsec, alarm_upmin, alarm_uphour, edit_mode, field_sel,
               armed, ringing, ring_blink
    );
endinterface

// File: rtl/alarm_controller.sv
// Alarm controller: turns PS/2 key levels into edit-cursor moves and alarm
// counter increment pulses, arms/disarms the alarm, and runs the
// ring / acknowledge / timeout sequence on a rising current==alarm match.
module alarm_controller #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned EDIT_TIMEOUT_S = 10
) (
    input  logic              clk,
    input  logic              reset,
    alarm_controller_if.slave bus
);
    localparam logic [7:0] RING_LIM = 8'(RING_SECONDS);
    localparam logic [7:0] EDIT_LIM = 8'(EDIT_TIMEOUT_S);
    localparam logic [1:0] F_SEC  = 2'd0;
    localparam logic [1:0] F_MIN  = 2'd1;
    localparam logic [1:0] F_HOUR = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EDIT = 2'd1,
        RING = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] key_q;             // previous key levels {down,right,left,up}
    logic [3:0] key_now;
    logic [3:0] rise;
    logic       match_q, match_now, hit;
    logic       ev_down, ev_right, ev_left, ev_up, ev_any;
    logic [1:0] field_q, field_d;
    logic       armed_q, armed_d;
    logic       blink_q, blink_d;
    logic [7:0] cnt_q, cnt_d;      // idle seconds in EDIT, ring seconds in RING
    logic [2:0] up_q, up_d;        // {hour,min,sec} increment pulses

    assign key_now   = {bus.down_key, bus.right_key, bus.left_key, bus.up_key};
    assign rise      = key_now & ~key_q;
    // Only the highest-priority rise counts: down > right > left > up
    assign ev_down   = rise[3];
    assign ev_right  = rise[2] & ~rise[3];
    assign ev_left   = rise[1] & ~(|rise[3:2]);
    assign ev_up     = rise[0] & ~(|rise[3:1]);
    assign ev_any    = |rise;
    assign match_now = (bus.cur_time == bus.alarm_time);
    assign hit       = match_now & ~match_q;

    // State, edge history and output registers; reset forces idle values
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            match_q <= 1'b0;
            field_q <= F_HOUR;
            armed_q <= 1'b0;
            blink_q <= 1'b0;
            cnt_q   <= '0;
            up_q    <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_now;
            match_q <= match_now;
            field_q <= field_d;
            armed_q <= armed_d;
            blink_q <= blink_d;
            cnt_q   <= cnt_d;
            up_q    <= up_d;
        end
    end

    // Next state: a fresh match wins over keys in IDLE; any key acks a ring
    always_comb begin
        state_d = state_q;
        field_d = field_q;
        armed_d = armed_q;
        blink_d = blink_q;
        cnt_d   = cnt_q;
        up_d    = '0;
        case (state_q)
            IDLE: begin
                if (hit && armed_q) begin
                    state_d = RING;
                    cnt_d   = '0;
                    blink_d = 1'b0;
                end else if (ev_right) begin
                    state_d = EDIT;
                    field_d = F_HOUR;
                    cnt_d   = '0;
                end else if (ev_down) begin
                    armed_d = ~armed_q;
                end
            end
            EDIT: begin
                if (ev_any) begin
                    cnt_d = '0;
                end
                if (ev_down) begin
                    state_d = IDLE;
                    field_d = F_HOUR;
                end else if (ev_right) begin
                    if (field_q == F_SEC) begin
                        state_d = IDLE;
                        armed_d = 1'b1;
                        field_d = F_HOUR;
                    end else begin
                        field_d = field_q - 2'd1;
                    end
                end else if (ev_left) begin
                    if (field_q != F_HOUR) begin
                        field_d = field_q + 2'd1;
                    end
                end else if (ev_up) begin
                    case (field_q)
                        F_SEC:   up_d = 3'b001;
                        F_MIN:   up_d = 3'b010;
                        default: up_d = 3'b100;
                    endcase
                end else if (bus.sec_tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == EDIT_LIM) begin
                        state_d = IDLE;
                        field_d = F_HOUR;
                    end
                end
            end
            RING: begin
                if (ev_any) begin
                    state_d = IDLE;
                    blink_d = 1'b0;
                end else if (bus.sec_tick) begin
                    cnt_d   = cnt_q + 8'd1;
                    blink_d = ~blink_q;
                    if (cnt_q + 8'd1 == RING_LIM) begin
                        state_d = IDLE;
                        blink_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.alarm_upsec  = up_q[0];
    assign bus.alarm_upmin  = up_q[1];
    assign bus.alarm_uphour = up_q[2];
    assign bus.edit_mode    = (state_q == EDIT);
    assign bus.field_sel    = field_q;
    assign bus.armed        = armed_q;
    assign bus.ringing      = (state_q == RING);
    assign bus.ring_blink   = blink_q;
endmodule

// File: tb/tb_alarm_controller.sv
// Bench for alarm_controller: directed scenarios followed by random key,
// tick and time activity, checked cycle by cycle against a reference model
// through an expected-output queue.
module tb_alarm_controller;
    localparam int RING_S = 60;
    localparam int EDIT_S = 10;

    logic clk = 1'b0;
    logic reset;
    alarm_controller_if bus();

    alarm_controller #(.RING_SECONDS(RING_S), .EDIT_TIMEOUT_S(EDIT_S)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Expected output after each edge:
    // {upsec, upmin, uphour, edit_mode, field_sel[1:0], armed, ringing, ring_blink}
    logic [8:0] sb[$];

    // Stimulus state held between cycles
    bit        r_rst;
    bit [3:0]  r_keys;   // {down,right,left,up}
    bit        r_tick;
    bit [23:0] r_cur;
    bit [23:0] r_alm;

    // Reference model state
    string     m_mode;   // "idle", "edit", "ring"
    int        m_field;  // 2 = hour, 1 = min, 0 = sec
    int        m_secs;   // seconds counted in the current mode
    bit        m_armed;
    bit        m_blink;
    bit [3:0]  m_prev;
    bit        m_was_match;

    // Apply one clock's worth of inputs to the model and return the outputs expected after the edge
    task automatic model_step(output logic [8:0] exp);
        bit [3:0] rose;
        string    ev;
        bit       hit;
        bit       ps, pm, ph;
        ps = 0; pm = 0; ph = 0;
        if (r_rst) begin
            m_mode = "idle"; m_field = 2; m_secs = 0; m_armed = 0; m_blink = 0;
            m_prev = '0; m_was_match = 0;
        end else begin
            rose = r_keys & ~m_prev;
            if (rose[3])      ev = "down";
            else if (rose[2]) ev = "right";
            else if (rose[1]) ev = "left";
            else if (rose[0]) ev = "up";
            else              ev = "none";
            hit = (r_cur == r_alm) && !m_was_match;
            if (m_mode == "idle") begin
                if (hit && m_armed) begin
                    m_mode = "ring"; m_secs = 0; m_blink = 0;
                end else if (ev == "right") begin
                    m_mode = "edit"; m_field = 2; m_secs = 0;
                end else if (ev == "down") begin
                    m_armed = !m_armed;
                end
            end else if (m_mode == "edit") begin
                if (ev != "none") m_secs = 0;
                if (ev == "down") begin
                    m_mode = "idle"; m_field = 2;
                end else if (ev == "right") begin
                    if (m_field == 0) begin
                        m_mode = "idle"; m_armed = 1; m_field = 2;
                    end else begin
                        m_field = m_field - 1;
                    end
                end else if (ev == "left") begin
                    m_field = (m_field >= 2) ? 2 : m_field + 1;
                end else if (ev == "up") begin
                    ps = (m_field == 0); pm = (m_field == 1); ph = (m_field == 2);
                end else if (r_tick) begin
                    m_secs++;
                    if (m_secs == EDIT_S) begin
                        m_mode = "idle"; m_field = 2;
                    end
                end
            end else begin
                if (ev != "none") begin
                    m_mode = "idle"; m_blink = 0;
                end else if (r_tick) begin
                    m_secs++;
                    m_blink = !m_blink;
                    if (m_secs == RING_S) begin
                        m_mode = "idle"; m_blink = 0;
                    end
                end
            end
            m_prev = r_keys;
            m_was_match = (r_cur == r_alm);
        end
        exp = {ps, pm, ph, (m_mode == "edit"), 2'(m_field), m_armed, (m_mode == "ring"), m_blink};
    endtask

    // Drive the held stimulus for n cycles, queueing the expected response each time
    task automatic cyc(input int n);
        logic [8:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset          = r_rst;
            bus.down_key   = r_keys[3];
            bus.right_key  = r_keys[2];
            bus.left_key   = r_keys[1];
            bus.up_key     = r_keys[0];
            bus.sec_tick   = r_tick;
            bus.cur_time   = r_cur;
            bus.alarm_time = r_alm;
            model_step(exp);
            sb.push_back(exp);
        end
    endtask

    task automatic press(input int k);
        r_keys[k] = 1'b1; cyc(1);
        r_keys[k] = 1'b0; cyc(1);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            r_tick = 1'b1; cyc(1);
            r_tick = 1'b0; cyc(1);
        end
    endtask

    // Monitor: compares every presented output against the oldest expectation
    initial begin
        logic [8:0] exp;
        logic [8:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                act = {bus.alarm_upsec, bus.alarm_upmin, bus.alarm_uphour, bus.edit_mode,
                       bus.field_sel, bus.armed, bus.ringing, bus.ring_blink};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs t=%0t got {up s/m/h,edit,field,armed,ring,blink}=%b required %b",
                             $time, act, exp);
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.left_key = 0; bus.right_key = 0; bus.up_key = 0; bus.down_key = 0;
        bus.sec_tick = 0; bus.cur_time = 24'h123456; bus.alarm_time = 24'h070000;
        r_rst = 1; r_keys = '0; r_tick = 0; r_cur = 24'h123456; r_alm = 24'h070000;

        // Reset values
        cyc(2);
        r_rst = 0;
        cyc(2);

        // Enter EDIT, then one held up press gives one hour pulse
        press(2);
        r_keys[0] = 1; cyc(3);
        r_keys[0] = 0; cyc(2);

        // right, up, right, up, up, right: one min pulse, two sec pulses, exit armed
        press(2); press(0); press(2); press(0); press(0); press(2);
        cyc(2);

        // Rising match rings; 60 ticks end the ring
        r_cur = 24'h065959; cyc(2);
        r_cur = 24'h070000; cyc(3);
        ticks(RING_S);
        cyc(4);

        // Ring again, ack with left after 5 ticks, no re-ring while still matching
        r_cur = 24'h065959; cyc(2);
        r_cur = 24'h070000; cyc(2);
        ticks(5);
        press(1);
        cyc(10);

        // EDIT abandoned after 10 idle ticks
        press(2);
        ticks(EDIT_S);
        cyc(2);

        // Match during EDIT does not ring, not even on exit
        press(2);
        r_cur = 24'h065959; cyc(2);
        r_cur = 24'h070000; cyc(3);
        press(3);
        cyc(3);

        // Simultaneous right and down in IDLE: down wins and toggles armed
        r_keys = 4'b1100; cyc(1);
        r_keys = 4'b0000; cyc(2);
        press(3);

        // Reset in the middle of a ring
        r_cur = 24'h065959; cyc(2);
        r_cur = 24'h070000; cyc(2);
        ticks(3);
        r_rst = 1; cyc(1);
        r_rst = 0; cyc(3);

        // Random activity around the alarm time
        for (int i = 0; i < 4000; i++) begin
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 5) == 0) r_keys[k] = ~r_keys[k];
            r_tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0) begin
                case ($urandom_range(0, 2))
                    0:       r_cur = 24'h065959;
                    1:       r_cur = 24'h070000;
                    default: r_cur = 24'h070001;
                endcase
            end
            if ($urandom_range(0, 199) == 0) r_alm = r_cur;
            r_rst = ($urandom_range(0, 999) == 0);
            cyc(1);
        end
        r_rst = 0; r_keys = '0; r_tick = 0;
        cyc(3);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
Sequences the alarm-time counter and the alarm output from PS/2 key events. It sits between the four kb_controller key outputs, the 1 Hz tick, and the current/alarm time counters.
- Owns the edit cursor and generates single-cycle increment pulses for the alarm counter.
- Arms and disarms the alarm, detects the current-time/alarm-time match, and runs the ring/acknowledge/timeout sequence.
- Exposes edit state for vga_out highlighting.

Parameters:
RING_SECONDS, 60, sec_tick count after which an unacknowledged ring ends (1..255)
EDIT_TIMEOUT_S, 10, sec_tick count with no key event after which EDIT is abandoned (1..255)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
left_key  in  1  level from kb_controller; block edge-detects internally
right_key  in  1  level
up_key  in  1  level
down_key  in  1  level
sec_tick  in  1  one-clk pulse at 1 Hz, clk domain
cur_time  in  24  {hourMSB,hourLSB,minMSB,minLSB,secMSB,secLSB}, BCD
alarm_time  in  24  same packing, from alarm counter
alarm_upsec  out  1  one-clk increment pulse to alarm counter
alarm_upmin  out  1  one-clk increment pulse
alarm_uphour  out  1  one-clk increment pulse
edit_mode  out  1  high in EDIT
field_sel  out  2  0=SEC, 1=MIN, 2=HOUR; 3 never driven
armed  out  1  alarm enabled
ringing  out  1  high in RING
ring_blink  out  1  toggles on each sec_tick while ringing, else 0

Behaviour:
- Reset: state=IDLE, field_sel=2, armed=0, ringing=0, ring_blink=0, all up pulses=0, edge registers=0, match_d=0, counters=0.
- Key events: rise = key & ~key_d (registered previous level). One event per clk. Priority when several rise in the same cycle: down > right > left > up; lower-priority rises that cycle are dropped.
- match = (cur_time == alarm_time), all 24 bits. match_d is registered every cycle in every state. hit = match & ~match_d.
- IDLE:
  - right → EDIT, field_sel=2, idle counter=0.
  - down → toggle armed.
  - left and up ignored.
  - hit & armed → RING, ring counter=0, ring_blink=0.
  - hit takes precedence over a same-cycle key event; that key event is dropped.
- EDIT:
  - right → field_sel steps 2→1→0. When right occurs at field_sel=0 → IDLE, armed=1, field_sel=2.
  - left → field_sel+1, saturating at 2.
  - up → one-cycle pulse on the output for field_sel, registered: pulse appears the cycle after the rise.
  - down → IDLE, armed unchanged, field_sel=2.
  - Any key event clears the idle counter.
  - sec_tick increments the idle counter. When it reaches EDIT_TIMEOUT_S → IDLE, armed unchanged, field_sel=2.
  - hit ignored; no ring.
- RING:
  - ringing=1.
  - Any key event (ack) → IDLE, armed stays 1, ringing=0, ring_blink=0 next cycle.
  - sec_tick → ring counter+1 and ring_blink toggles. When the counter reaches RING_SECONDS → IDLE, same outputs as ack.
  - Ack and final tick in the same cycle → IDLE, single transition.
- Rising-edge match only:
  - An alarm set equal to the current time while editing does not ring on exit.
  - After an ack within the matching second, no re-ring occurs.
- Up pulses are never asserted outside EDIT. At most one up pulse is high in any cycle.
- Reset asserted mid-RING or mid-EDIT returns everything to reset values on the next clk edge. No pulse is emitted on that cycle.
- Registered outputs only; no combinational path from inputs to outputs.

Test Plan:
- Reset, then a right rise → edit_mode=1, field_sel=2. Then up held 3 clk (one rise) → exactly one alarm_uphour pulse, one cycle after the rise.
- EDIT at field 2: right, up, right, up, up, right → one alarm_upmin pulse, two alarm_upsec pulses. After the final right: IDLE, armed=1, field_sel=2.
- armed=1, IDLE, alarm_time=24'h070000, cur_time steps 24'h065959→24'h070000 → ringing=1 the cycle after the match. After 60 sec_ticks → ringing=0, armed=1; ring_blink toggled 60 times.
- RING, then left rise after 5 ticks → ringing=0 next cycle. cur_time still 24'h070000 for further cycles → no re-ring.
- EDIT, 10 sec_ticks with no key → edit_mode=0, armed unchanged. A match occurring during EDIT → ringing stays 0.
- In IDLE, right and down rise in the same cycle → armed toggles, state stays IDLE. In RING, reset pulse → all outputs at reset values.
